memtest_databus_control: RTL

- Control FSM for the memory data-bus walking-ones test.
- Sequences the memTestDataBus datapath: register reset, pattern load, write, read-back, compare and advance.
- Runs the memory request/acknowledge handshake against one fixed test address.
- Reports pass/fail, the failing step index and a timeout flag to the test top level.

---
 rtl/memtest_databus_control_if.sv | 28 ++
 rtl/memtest_databus_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/memtest_databus_control_if.sv
`default_nettype none
// ============================================================================
// memtest_databus_control_if : memory request/acknowledge bus
// Rev 1.0 - initial release
// ============================================================================
interface memtest_databus_control_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_wr_req;
  logic                  o_mem_rd_req;
  logic                  i_mem_ack;

  modport master (
    output o_mem_addr,
    output o_mem_wr_req,
    output o_mem_rd_req,
    input  i_mem_ack
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_wr_req,
    input  o_mem_rd_req,
    output i_mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/memtest_databus_control.sv
`default_nettype none
// ============================================================================
// memtest_databus_control : walking-ones data-bus test sequencer
// Optional ack timeout enabled by defining MEMTEST_DATABUS_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
module memtest_databus_control #(
  parameter int                    DATUM_WIDTH    = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] TEST_ADDRESS   = '0,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n_async,
  input  logic                          i_start,
  memtest_databus_control_if.master     mem,
  input  logic                          i_equal_address_pattern,
  input  logic                          i_equal_zero_pattern,
  output logic                          o_rst_reg,
  output logic                          o_ena_reg_pattern,
  output logic                          o_ena_reg_address,
  output logic                          o_sel_mux_pattern_memory,
  output logic                          o_RL_shifter,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic [$clog2(DATUM_WIDTH):0]  o_fail_step,
  output logic                          o_timeout
);

  localparam int STEP_W = $clog2(DATUM_WIDTH) + 1;
  localparam logic [STEP_W-1:0] c_step_max = STEP_W'(DATUM_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_WRITE, S_READ, S_CHECK, S_PASS, S_FAIL
  } state_t;

  state_t              r_state, w_next;
  logic [STEP_W-1:0]   r_step;
  logic                r_pass;
  logic [STEP_W-1:0]   r_fail_step;
  logic                r_timeout;
  logic                w_clear_result, w_step_inc, w_set_pass, w_set_fail, w_set_timeout;
  logic                w_tmo_hit;

`ifdef MEMTEST_DATABUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts un-acked cycles of the current request; any state change clears it.
  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async)
      r_tmo_cnt <= '0;
    else if ((r_state == S_WRITE || r_state == S_READ) && !mem.i_mem_ack && w_next == r_state)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else
      r_tmo_cnt <= '0;
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n_async) begin
    if (!i_rst_n_async) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_pass      <= 1'b0;
      r_fail_step <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear_result) begin
        r_step      <= '0;
        r_pass      <= 1'b0;
        r_fail_step <= '0;
        r_timeout   <= 1'b0;
      end
      if (w_step_inc && r_step < c_step_max)
        r_step <= r_step + 1'b1;
      if (w_set_pass)
        r_pass <= 1'b1;
      if (w_set_fail || w_set_timeout) begin
        r_pass      <= 1'b0;
        r_fail_step <= r_step;
      end
      if (w_set_timeout)
        r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next                   = r_state;
    w_clear_result           = 1'b0;
    w_step_inc               = 1'b0;
    w_set_pass               = 1'b0;
    w_set_fail               = 1'b0;
    w_set_timeout            = 1'b0;
    o_rst_reg                = 1'b0;
    o_ena_reg_pattern        = 1'b0;
    o_ena_reg_address        = 1'b0;
    o_sel_mux_pattern_memory = 1'b0;
    o_done                   = 1'b0;
    mem.o_mem_wr_req         = 1'b0;
    mem.o_mem_rd_req         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next         = S_CLEAR;
          w_clear_result = 1'b1;
        end
      end
      S_CLEAR: begin
        o_rst_reg = 1'b1;
        w_next    = S_LOAD;
      end
      S_LOAD: begin
        o_ena_reg_address = 1'b1;
        w_next            = S_WRITE;
      end
      S_WRITE: begin
        mem.o_mem_wr_req = 1'b1;
        if (mem.i_mem_ack) begin
          w_next = S_READ;
        end else if (w_tmo_hit) begin
          w_next        = S_FAIL;
          w_set_timeout = 1'b1;
        end
      end
      S_READ: begin
        mem.o_mem_rd_req         = 1'b1;
        o_sel_mux_pattern_memory = 1'b1;
        if (mem.i_mem_ack) begin
          w_next = S_CHECK;
        end else if (w_tmo_hit) begin
          w_next        = S_FAIL;
          w_set_timeout = 1'b1;
        end
      end
      S_CHECK: begin
        // A mismatch takes priority over the last-pattern flag.
        if (!i_equal_address_pattern) begin
          w_next     = S_FAIL;
          w_set_fail = 1'b1;
        end else if (i_equal_zero_pattern) begin
          w_next     = S_PASS;
          w_set_pass = 1'b1;
        end else begin
          o_ena_reg_pattern = 1'b1;
          w_step_inc        = 1'b1;
          w_next            = S_LOAD;
        end
      end
      S_PASS: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      S_FAIL: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy         = (r_state != S_IDLE);
  assign mem.o_mem_addr = o_busy ? TEST_ADDRESS : '0;
  assign o_RL_shifter   = 1'b1;
  assign o_pass         = r_pass;
  assign o_fail_step    = r_fail_step;
  assign o_timeout      = r_timeout;

endmodule
`default_nettype wire
